shift_request_sequencer: RTL

Upstream feeder for the pipelined barrel shifter. It accepts one N-lane vector plus a start offset and a rotation count over a valid/ready handshake. It then issues that vector to the shifter once per cycle, with `sel` stepping modulo N. Alongside, it carries a valid/last/index tag through a delay line matched to the shifter's pipeline depth, so downstream logic knows which shifter outputs are live.

---
 rtl/shifter_pkg.sv | 13 +
 rtl/tag_delay_line.sv | 24 ++
 rtl/shift_request_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the barrel-shifter front end: default geometry and
// the request sequencer state type.
package shifter_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 16;
    localparam int DEF_K     = 4;
    localparam int DEF_LAT   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_e;
endpackage

// File: rtl/tag_delay_line.sv
// Register chain that keeps a small tag aligned with the free-running shifter
// pipeline; every stage is cleared on reset.
module tag_delay_line #(
    parameter int DEPTH = 4,
    parameter int DW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);
    logic [DEPTH-1:0][DW-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/shift_request_sequencer.sv
// Feeds the pipelined barrel shifter: replays one latched vector with a
// select stepping modulo N and tags each issue through a matched delay line.
module shift_request_sequencer
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int K     = DEF_K,
    parameter int LAT   = DEF_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [K-1:0]       req_start,
    input  logic [K:0]         req_count,
    input  logic               issue_en,
    output logic [N*WIDTH-1:0] shift_in,
    output logic [K-1:0]       shift_sel,
    output logic               issue_valid,
    output logic               out_valid,
    output logic               out_last,
    output logic [K-1:0]       out_index
);
    localparam logic [K:0] FULL_COUNT = (K+1)'(N);
    localparam logic [K:0] ONE_LEFT   = (K+1)'(1);

    seq_state_e         state, state_next;
    logic [N*WIDTH-1:0] data_r;
    logic [K-1:0]       sel_r;
    logic [K:0]         remaining;
    logic [K:0]         count_sat;
    logic               last_r;
    logic               fire, is_last, accept;

    // Illegal counts above N clamp to a full sweep.
    assign count_sat = (req_count > FULL_COUNT) ? FULL_COUNT : req_count;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        fire       = 1'b0;
        is_last    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (accept && count_sat != '0) state_next = ISSUE;
            end
            ISSUE: begin
                fire      = issue_en;
                is_last   = issue_en && (remaining == ONE_LEFT);
                // The last issue frees the slot, so the next request can chain in.
                req_ready = is_last;
                accept    = is_last && req_valid;
                if (is_last) state_next = (accept && count_sat != '0) ? ISSUE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_r      <= '0;
            sel_r       <= '0;
            remaining   <= '0;
            shift_in    <= '0;
            shift_sel   <= '0;
            issue_valid <= 1'b0;
            last_r      <= 1'b0;
        end else begin
            issue_valid <= fire;
            last_r      <= is_last;
            if (fire) begin
                shift_in  <= data_r;
                shift_sel <= sel_r;
                sel_r     <= sel_r + 1'b1;
                remaining <= remaining - 1'b1;
            end
            // A chained accept overrides the step of the issue it coincides with.
            if (accept) begin
                data_r    <= req_data;
                sel_r     <= req_start;
                remaining <= count_sat;
            end
        end
    end

    tag_delay_line #(
        .DEPTH (LAT),
        .DW    (K + 2)
    ) u_tag_delay (
        .clk   (clk),
        .reset (reset),
        .din   ({issue_valid, last_r, shift_sel}),
        .dout  ({out_valid, out_last, out_index})
    );
endmodule
